// File: rtl/bcd_updown_counter_scan.sv
// Multi-digit BCD up/down counter with scanned 7-segment drive; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: count visible one cycle after the tick edge; seg_com/seg_data follow the registered scan index.
// Backpressure: none; en gates the prescaler, clr clears count and prescaler, scan free-runs.
module bcd_updown_counter_scan #(
    parameter int DIGITS    = 4,
    parameter int COUNT_DIV = 50000000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap,
    output logic [7:0]            seg_com,
    output logic [7:0]            seg_data
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]            pre;
    logic [SW-1:0]            scan_cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   cnt;
    logic [DIGITS-1:0][3:0]   cnt_nxt;
    logic                     carry_out;
    logic                     tick;
    logic [3:0]               cur;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'b1111_1100;
            4'd1:    seg7 = 8'b0110_0000;
            4'd2:    seg7 = 8'b1101_1010;
            4'd3:    seg7 = 8'b1111_0010;
            4'd4:    seg7 = 8'b0110_0110;
            4'd5:    seg7 = 8'b1011_0110;
            4'd6:    seg7 = 8'b1011_1110;
            4'd7:    seg7 = 8'b1110_0000;
            4'd8:    seg7 = 8'b1111_1110;
            4'd9:    seg7 = 8'b1111_0110;
            default: seg7 = 8'b0000_0000;
        endcase
    endfunction

    assign tick = en && (pre == PRE_MAX);
    assign bcd  = cnt;

    // Ripple carry/borrow across digits; a carry out of the top digit is a full-scale wrap.
    always_comb begin
        logic carry;
        cnt_nxt = cnt;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (cnt[i] == 4'd9) begin
                        cnt_nxt[i] = 4'd0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end else begin
                    if (cnt[i] == 4'd0) begin
                        cnt_nxt[i] = 4'd9;
                    end else begin
                        cnt_nxt[i] = cnt[i] - 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
        end
        carry_out = carry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            pre  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            if (en) begin
                pre <= tick ? '0 : pre + PW'(1);
            end
            if (tick) begin
                cnt <= cnt_nxt;
            end
            wrap <= tick && carry_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Walk from the most significant digit down so the leading-zero run is known at each position.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lz;
        logic blank;
        lz    = 1'b1;
        blank = 1'b0;
`endif
        seg_com = 8'hFF;
        cur     = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            lz = lz && (cnt[i] == 4'd0);
`endif
            if (idx == IW'(i)) begin
                seg_com[7-i] = 1'b0;
                cur          = cnt[i];
`ifdef LEADING_ZERO_BLANK_EN
                blank        = lz && (i != 0);
`endif
            end
        end
        seg_data = seg7(cur);
`ifdef LEADING_ZERO_BLANK_EN
        if (blank) begin
            seg_data = 8'h00;
        end
`endif
    end

endmodule

// File: tb/tb_bcd_updown_counter_scan.sv
// Two counter configurations driven by shared random stimulus, scoreboarded against an arithmetic model.
module tb_bcd_updown_counter_scan;

    localparam int D0 = 4, C0 = 2, S0 = 1;
    localparam int D1 = 3, C1 = 1, S1 = 3;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic up  = 1'b1;
    logic clr = 1'b0;

    logic [15:0] bcd_a;
    logic [11:0] bcd_b;
    logic        wrap_a, wrap_b;
    logic [7:0]  com_a, com_b, seg_a, seg_b;

    always #5 clk = ~clk;

    bcd_updown_counter_scan #(.DIGITS(D0), .COUNT_DIV(C0), .SCAN_DIV(S0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
        .bcd(bcd_a), .wrap(wrap_a), .seg_com(com_a), .seg_data(seg_a)
    );

    bcd_updown_counter_scan #(.DIGITS(D1), .COUNT_DIV(C1), .SCAN_DIV(S1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
        .bcd(bcd_b), .wrap(wrap_b), .seg_com(com_b), .seg_data(seg_b)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        wrap;
        logic [7:0]  com;
        logic [7:0]  seg;
    } exp_t;
    typedef exp_t [1:0] pair_t;

    pair_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] act_bcd  [2];
    logic        act_wrap [2];
    logic [7:0]  act_com  [2];
    logic [7:0]  act_seg  [2];
    assign act_bcd[0]  = bcd_a;
    assign act_bcd[1]  = {4'h0, bcd_b};
    assign act_wrap[0] = wrap_a;
    assign act_wrap[1] = wrap_b;
    assign act_com[0]  = com_a;
    assign act_com[1]  = com_b;
    assign act_seg[0]  = seg_a;
    assign act_seg[1]  = seg_b;

    // Reference model: count held as a plain integer, prescaler and scan as integers.
    int   dg  [2] = '{D0, D1};
    int   cdv [2] = '{C0, C1};
    int   sdv [2] = '{S0, S1};
    int   mval[2];
    int   mpre[2];
    int   mscn[2];
    int   midx[2];
    logic mwrp[2];
    logic [7:0] pat [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic exp_t predict(input int k);
        exp_t e;
        int   v;
        e     = '0;
        v     = mval[k];
        for (int i = 0; i < dg[k]; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.wrap = mwrp[k];
        e.com  = ~(8'h80 >> midx[k]);
        e.seg  = pat[(mval[k] / pow10(midx[k])) % 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (midx[k] != 0 && (mval[k] / pow10(midx[k])) == 0) e.seg = 8'h00;
`endif
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mval[k] = 0; mpre[k] = 0; mscn[k] = 0; midx[k] = 0; mwrp[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic u, input logic c);
        int  m;
        bit  tk;
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                mval[k] = 0; mpre[k] = 0; mscn[k] = 0; midx[k] = 0; mwrp[k] = 1'b0;
                continue;
            end
            if (mscn[k] == sdv[k] - 1) begin
                mscn[k] = 0;
                midx[k] = (midx[k] + 1) % dg[k];
            end else begin
                mscn[k] = mscn[k] + 1;
            end
            m  = pow10(dg[k]);
            tk = e && (mpre[k] == cdv[k] - 1);
            if (c) begin
                mval[k] = 0; mpre[k] = 0; mwrp[k] = 1'b0;
            end else begin
                if (e) mpre[k] = tk ? 0 : mpre[k] + 1;
                mwrp[k] = 1'b0;
                if (tk) begin
                    if (u) begin
                        mwrp[k] = (mval[k] == m - 1);
                        mval[k] = (mval[k] + 1) % m;
                    end else begin
                        mwrp[k] = (mval[k] == 0);
                        mval[k] = (mval[k] + m - 1) % m;
                    end
                end
            end
        end
    endtask

    task automatic check(input int k, input exp_t e);
        vectors++;
        if ({act_bcd[k], act_wrap[k], act_com[k], act_seg[k]} !== e) begin
            miscompares++;
            $display("FAIL inst%0d t=%0t bcd/wrap/com/seg got %h/%b/%b/%b want %h/%b/%b/%b",
                     k, $time, act_bcd[k], act_wrap[k], act_com[k], act_seg[k],
                     e.bcd, e.wrap, e.com, e.seg);
        end
    endtask

    function automatic pair_t predict_pair();
        pair_t p;
        p[0] = predict(0);
        p[1] = predict(1);
        return p;
    endfunction

    // Monitor: one scoreboard entry per clock edge, compared after the edge settles.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                p = sb.pop_front();
                check(0, p[0]);
                check(1, p[1]);
            end
        end
    end

    initial begin
        pair_t p;
        model_reset();
        #3;
        p = predict_pair();
        check(0, p[0]);
        check(1, p[1]);
        sb.push_back(p);
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            if (i == 700 || i == 1900) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                sb.delete();
                p = predict_pair();
                check(0, p[0]);
                check(1, p[1]);
                sb.push_back(p);
                continue;
            end
            rst = 1'b1;
            if (i < 20) begin
                en = 1'b1; up = 1'b1; clr = 1'b0;
            end else if (i < 30) begin
                en = 1'b0; up = 1'($urandom_range(0, 1)); clr = 1'b0;
            end else begin
                en  = ($urandom_range(0, 9) != 0);
                up  = ($urandom_range(0, 3) != 0) ^ (((i / 300) % 2) == 1);
                clr = ($urandom_range(0, 40) == 0);
            end
            model_step(rst, en, up, clr);
            sb.push_back(predict_pair());
        end
        repeat (3) @(posedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_scan.md
Name: bcd_updown_counter_scan

Overview:
- Parametrised multi-digit BCD up/down counter with a time-multiplexed 7-segment display driver.
- Generalises the single-digit count-and-display block:
  - up to 8 digits;
  - count-rate prescaler;
  - direction control;
  - synchronous clear;
  - wrap pulse;
  - scanned digit commons.
- Sits between board-level clock/reset and the 8-digit common-anode display header.

Parameters:
- DIGITS, 4, number of BCD digits counted and scanned (legal 1..8).
- COUNT_DIV, 50000000, clk cycles per count step while enabled (legal >= 1).
- SCAN_DIV, 50000, clk cycles each digit stays selected (legal >= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  count enable; prescaler advances only while high.
- up  input  1  direction, 1 = increment, 0 = decrement; sampled at each count step.
- clr  input  1  synchronous clear of count and prescaler.
- bcd  output  4*DIGITS  current count, digit i at bits [4i+3:4i], digit 0 least significant.
- wrap  output  1  one-cycle pulse on full-scale wrap in either direction.
- seg_com  output  8  digit commons, active-low one-hot; digit i drives seg_com[7-i].
- seg_data  output  8  segments {a,b,c,d,e,f,g,dp}, active-high.

Behaviour:
- Reset (rst low, asynchronous), values held until rst is released:
  - all digits = 0, prescaler = 0, scan counter = 0, scan index = 0, wrap = 0;
  - seg_com = 8'b0111_1111;
  - seg_data = pattern for 0.
- Prescaler:
  - counts 0..COUNT_DIV-1 while en = 1, holds while en = 0.
  - Count step ("tick") occurs in the cycle where prescaler = COUNT_DIV-1 and en = 1; prescaler returns to 0 in that cycle.
  - COUNT_DIV = 1 gives a tick every enabled cycle.
- Count update on tick, registered: the new bcd value is visible the cycle after the tick edge.
- Up:
  - digit 0 increments;
  - a digit at 9 goes to 0 and carries into the next digit.
- Down:
  - digit 0 decrements;
  - a digit at 0 goes to 9 and borrows from the next digit.
- Wrap:
  - up from all-9s -> all-0s, and down from all-0s -> all-9s.
  - wrap = 1 for exactly the cycle in which bcd shows the wrapped value, else 0.
- clr:
  - clr = 1 sets all digits and the prescaler to 0 at the next edge and forces wrap = 0.
  - clr has priority over a simultaneous tick.
  - Scan logic is unaffected by clr.
- Changing up between ticks has no effect until the next tick; no intermediate steps are taken.
- Digits never hold values 10..15.
- Scan:
  - scan counter runs 0..SCAN_DIV-1 continuously, independent of en and clr.
  - At SCAN_DIV-1 the scan index advances: 0..DIGITS-1, then wraps to 0.
  - With DIGITS = 1 the index stays 0.
- seg_com:
  - bit 7-index = 0, all other bits = 1.
  - Bits for positions >= DIGITS are always 1.
- seg_data:
  - combinational from the registered scan index and the registered count, so it always matches the active common;
  - dp (bit 0) = 0.
- Segment encoding:
  - 0 = 11111100, 1 = 01100000, 2 = 11011010, 3 = 11110010, 4 = 01100110
  - 5 = 10110110, 6 = 10111110, 7 = 11100000, 8 = 11111110, 9 = 11110110
- Reset asserted mid-count or mid-scan returns everything to the reset values immediately.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - while the active digit and every more-significant digit are 0, seg_data = 8'b0000_0000 (blank);
  - digit 0 is never blanked;
  - seg_com scanning is unchanged.
- Undefined: every digit is always displayed, including leading zeros.
- bcd and wrap are identical in both builds.

Test Plan:
- Reset, DIGITS=4, COUNT_DIV=2, SCAN_DIV=1: assert rst=0 mid-operation -> bcd=16'h0000, wrap=0, seg_com=8'b0111_1111, seg_data=11111100 without waiting for a clock edge.
- Up count, en=1, up=1, COUNT_DIV=2: 20 cycles -> bcd=16'h0010; digit 0 passes 9->0 with carry into digit 1.
- Up wrap: count to 16'h9999, one more tick -> bcd=16'h0000, wrap high for one cycle only.
- Down wrap and direction change:
  - up=0 from 16'h0000, one tick -> bcd=16'h9999, wrap pulse.
  - Set up=1 mid-prescale -> next tick gives 16'h0000.
- clr and en:
  - clr=1 coincident with a tick at 16'h0042 -> bcd=16'h0000, no wrap.
  - en=0 for 10 cycles -> bcd constant, prescaler frozen.
- Scan, DIGITS=3, SCAN_DIV=1, bcd=12'h105: seg_com cycles 0111_1111 -> 1011_1111 -> 1101_1111 -> repeat; seg_data = 10110110, 11111100, 01100000 in step.
  - With LEADING_ZERO_BLANK_EN at bcd=12'h005: digits 1,2 show 00000000.
